// File: rtl/reg_context_mover_if.sv
// Data-memory request bus between the context mover (master) and memory (slave).
// One request at a time; a transfer completes on a rising edge with the request high and MEM_BUSYWAIT low.
interface reg_context_mover_if;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    modport master (
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT
    );

    modport slave (
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT
    );
endinterface

// File: rtl/reg_context_mover.sv
// Saves the 32-word register file to memory or restores it, one word per memory transfer.
// Save: 35 cycles unstalled from acceptance to DONE; MEM_BUSYWAIT freezes address, data and index.
module reg_context_mover (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          SAVE_REQ,
    input  logic          RESTORE_REQ,
    input  logic [31:0]   BASE_ADDR,
    output logic          BUSY,
    output logic          DONE,
    output logic          RF_READ_MEM,
    output logic          RF_WRITE_MEM,
    input  logic [1023:0] RF_OUT_DATA,
    output logic [1023:0] RF_IN_DATA,
    reg_context_mover_if.master mem
);

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        SNAP_WAIT,
        STORE,
        LOAD,
        COMMIT,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [31:0]       base_q, base_d;
    logic [31:0][31:0] buf_q, buf_d;
    logic [31:0]       word_addr;

    assign word_addr  = base_q + {25'd0, idx_q, 2'b00};
    assign RF_IN_DATA = buf_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                // Save wins when both requests arrive together.
                if (SAVE_REQ) begin
                    base_d  = BASE_ADDR & ~32'h3;
                    idx_d   = '0;
                    state_d = SNAP;
                end else if (RESTORE_REQ) begin
                    base_d  = BASE_ADDR & ~32'h3;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            SNAP:      state_d = SNAP_WAIT;
            SNAP_WAIT: begin
                buf_d   = RF_OUT_DATA;
                state_d = STORE;
            end
            STORE: begin
                if (!mem.MEM_BUSYWAIT) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'd31) state_d = FIN;
                end
            end
            LOAD: begin
                if (!mem.MEM_BUSYWAIT) begin
                    buf_d[idx_q] = mem.MEM_READDATA;
                    idx_d        = idx_q + 5'd1;
                    if (idx_q == 5'd31) state_d = COMMIT;
                end
            end
            COMMIT:  state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSY              = (state_q != IDLE);
        DONE              = 1'b0;
        RF_READ_MEM       = 1'b0;
        RF_WRITE_MEM      = 1'b0;
        mem.MEM_READ      = 1'b0;
        mem.MEM_WRITE     = 1'b0;
        mem.MEM_ADDRESS   = '0;
        mem.MEM_WRITEDATA = '0;
        case (state_q)
            SNAP:   RF_READ_MEM = 1'b1;
            STORE: begin
                mem.MEM_WRITE     = 1'b1;
                mem.MEM_ADDRESS   = word_addr;
                mem.MEM_WRITEDATA = buf_q[idx_q];
            end
            LOAD: begin
                mem.MEM_READ    = 1'b1;
                mem.MEM_ADDRESS = word_addr;
            end
            COMMIT: RF_WRITE_MEM = 1'b1;
            FIN:    DONE = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_context_mover.sv
// Directed save/restore scenarios against a bench memory model with programmable stalls.
module tb_reg_context_mover;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          SAVE_REQ;
    logic          RESTORE_REQ;
    logic [31:0]   BASE_ADDR;
    logic          BUSY;
    logic          DONE;
    logic          RF_READ_MEM;
    logic          RF_WRITE_MEM;
    logic [1023:0] RF_OUT_DATA;
    logic [1023:0] RF_IN_DATA;

    reg_context_mover_if mif();

    reg_context_mover dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .SAVE_REQ     (SAVE_REQ),
        .RESTORE_REQ  (RESTORE_REQ),
        .BASE_ADDR    (BASE_ADDR),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .RF_READ_MEM  (RF_READ_MEM),
        .RF_WRITE_MEM (RF_WRITE_MEM),
        .RF_OUT_DATA  (RF_OUT_DATA),
        .RF_IN_DATA   (RF_IN_DATA),
        .mem          (mif.master)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: read data is a pattern derived from the address offset from rd_base.
    int          stall_n = 0;
    int          stall_cnt = 0;
    logic [31:0] rd_base = 32'h0;

    assign mif.MEM_READDATA = mif.MEM_READ ?
        (32'hA5A50000 + ((mif.MEM_ADDRESS - rd_base) >> 2)) : 32'h0;

    logic [31:0]   wr_addr[$];
    logic [31:0]   wr_dat[$];
    logic [31:0]   rd_addr[$];
    int            rf_rd_cnt, rf_wr_cnt, done_cnt, req_cycles;
    int            excl_viol = 0, stall_viol = 0, idle_viol = 0;
    logic [1023:0] commit_img = '0;
    logic          prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
    logic [31:0]   prev_addr = '0, prev_wdat = '0;

    initial mif.MEM_BUSYWAIT = 1'b0;

    always @(negedge CLK) begin
        if (mif.MEM_READ || mif.MEM_WRITE) begin
            if (stall_cnt < stall_n) begin
                mif.MEM_BUSYWAIT = 1'b1;
                stall_cnt++;
            end else begin
                mif.MEM_BUSYWAIT = 1'b0;
                stall_cnt = 0;
            end
        end else begin
            mif.MEM_BUSYWAIT = 1'b0;
            stall_cnt = 0;
        end
        if (mif.MEM_READ && mif.MEM_WRITE) excl_viol++;
        if (!mif.MEM_READ && !mif.MEM_WRITE && (mif.MEM_ADDRESS != 0 || mif.MEM_WRITEDATA != 0))
            idle_viol++;
        if (prev_stall && (mif.MEM_READ !== prev_rd || mif.MEM_WRITE !== prev_wr ||
                           mif.MEM_ADDRESS !== prev_addr || mif.MEM_WRITEDATA !== prev_wdat))
            stall_viol++;
        if (mif.MEM_READ || mif.MEM_WRITE) req_cycles++;
        if (!mif.MEM_BUSYWAIT && !RESET) begin
            if (mif.MEM_WRITE) begin
                wr_addr.push_back(mif.MEM_ADDRESS);
                wr_dat.push_back(mif.MEM_WRITEDATA);
            end
            if (mif.MEM_READ) rd_addr.push_back(mif.MEM_ADDRESS);
        end
        if (RF_READ_MEM) rf_rd_cnt++;
        if (RF_WRITE_MEM) begin
            rf_wr_cnt++;
            commit_img = RF_IN_DATA;
        end
        if (DONE) done_cnt++;
        prev_stall = (mif.MEM_READ || mif.MEM_WRITE) && mif.MEM_BUSYWAIT;
        prev_rd    = mif.MEM_READ;
        prev_wr    = mif.MEM_WRITE;
        prev_addr  = mif.MEM_ADDRESS;
        prev_wdat  = mif.MEM_WRITEDATA;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_dat.delete();
        rd_addr.delete();
        rf_rd_cnt  = 0;
        rf_wr_cnt  = 0;
        done_cnt   = 0;
        req_cycles = 0;
    endtask

    // n counts busy cycles; the cycle right after acceptance is cycle 1.
    task automatic wait_done(input int budget, output int n);
        n = 1;
        while (!DONE && n < budget) begin
            tick();
            n++;
        end
    endtask

    int n;
    int bad;

    initial begin
        RESET       = 1'b1;
        SAVE_REQ    = 1'b0;
        RESTORE_REQ = 1'b0;
        BASE_ADDR   = 32'h0;
        for (int i = 0; i < 32; i++) RF_OUT_DATA[i*32 +: 32] = 32'h1000 + i;
        clear_logs();
        tick();
        tick();
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_rfrd", RF_READ_MEM, 0);
        check("rst_rfwr", RF_WRITE_MEM, 0);
        check("rst_memrd", mif.MEM_READ, 0);
        check("rst_memwr", mif.MEM_WRITE, 0);
        check("rst_addr", mif.MEM_ADDRESS, 0);
        check("rst_rfin_zero", RF_IN_DATA == '0, 1);
        RESET = 1'b0;
        tick();

        // Save, no stalls
        clear_logs();
        BASE_ADDR = 32'h200;
        SAVE_REQ  = 1'b1;
        tick();
        SAVE_REQ = 1'b0;
        check("sv_busy", BUSY, 1);
        check("sv_snap", RF_READ_MEM, 1);
        wait_done(100, n);
        check("sv_latency", n, 35);
        tick();
        check("sv_done_pulse", DONE, 0);
        check("sv_idle", BUSY, 0);
        check("sv_rfrd_cnt", rf_rd_cnt, 1);
        check("sv_wr_cnt", wr_addr.size(), 32);
        check("sv_rd_cnt", rd_addr.size(), 0);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] !== 32'h200 + 4*i || wr_dat[i] !== 32'h1000 + i) bad++;
        check("sv_words", bad, 0);
        if (wr_addr.size() == 32) begin
            check("sv_last_addr", wr_addr[31], 32'h27C);
            check("sv_last_dat", wr_dat[31], 32'h101F);
        end

        // Restore with three stall cycles per access
        clear_logs();
        stall_n     = 3;
        rd_base     = 32'h400;
        BASE_ADDR   = 32'h400;
        RESTORE_REQ = 1'b1;
        tick();
        RESTORE_REQ = 1'b0;
        wait_done(1000, n);
        check("rs_done", DONE, 1);
        check("rs_latency", n, 130);
        tick();
        check("rs_rfwr_cnt", rf_wr_cnt, 1);
        check("rs_commit_w17", commit_img[17*32 +: 32], 32'hA5A50011);
        check("rs_rfin_w17", RF_IN_DATA[17*32 +: 32], 32'hA5A50011);
        check("rs_rfin_w0", RF_IN_DATA[31:0], 32'hA5A50000);
        check("rs_rfin_w31", RF_IN_DATA[31*32 +: 32], 32'hA5A5001F);
        check("rs_rd_cnt", rd_addr.size(), 32);
        check("rs_wr_cnt", wr_addr.size(), 0);
        check("rs_req_cycles", req_cycles, 128);
        if (rd_addr.size() == 32) begin
            check("rs_first_addr", rd_addr[0], 32'h400);
            check("rs_last_addr", rd_addr[31], 32'h47C);
        end

        // Both requests together: save wins
        clear_logs();
        stall_n     = 0;
        BASE_ADDR   = 32'h800;
        SAVE_REQ    = 1'b1;
        RESTORE_REQ = 1'b1;
        tick();
        SAVE_REQ    = 1'b0;
        RESTORE_REQ = 1'b0;
        wait_done(100, n);
        check("both_latency", n, 35);
        tick();
        check("both_rd_cnt", rd_addr.size(), 0);
        check("both_wr_cnt", wr_addr.size(), 32);
        if (wr_addr.size() == 32) begin
            check("both_addr0", wr_addr[0], 32'h800);
            check("both_dat5", wr_dat[5], 32'h1005);
        end

        // Reset in the middle of STORE at index 10
        clear_logs();
        BASE_ADDR = 32'h300;
        SAVE_REQ  = 1'b1;
        tick();
        SAVE_REQ = 1'b0;
        n = 0;
        while (!(mif.MEM_WRITE && mif.MEM_ADDRESS == 32'h328) && n < 100) begin
            tick();
            n++;
        end
        check("mid_reach", mif.MEM_ADDRESS, 32'h328);
        RESET = 1'b1;
        SAVE_REQ = 1'b1;
        tick();
        SAVE_REQ = 1'b0;
        check("mid_memwr", mif.MEM_WRITE, 0);
        check("mid_busy", BUSY, 0);
        check("mid_done", DONE, 0);
        check("mid_addr", mif.MEM_ADDRESS, 0);
        check("mid_rfin_zero", RF_IN_DATA == '0, 1);
        RESET = 1'b0;
        clear_logs();
        repeat (4) tick();
        check("mid_no_done", done_cnt, 0);
        check("mid_stay_idle", BUSY, 0);
        SAVE_REQ = 1'b1;
        tick();
        SAVE_REQ = 1'b0;
        wait_done(100, n);
        check("mid_restart_lat", n, 35);
        tick();
        check("mid_restart_cnt", wr_addr.size(), 32);
        if (wr_addr.size() > 0) check("mid_restart_addr0", wr_addr[0], 32'h300);

        // Restore across the top of the address space; requests while busy ignored
        clear_logs();
        stall_n     = 1;
        rd_base     = 32'hFFFF_FFF0;
        BASE_ADDR   = 32'hFFFF_FFF3;
        RESTORE_REQ = 1'b1;
        tick();
        BASE_ADDR = 32'h1234_5678;
        SAVE_REQ  = 1'b1;
        repeat (3) tick();
        SAVE_REQ    = 1'b0;
        RESTORE_REQ = 1'b0;
        wait_done(500, n);
        check("wrap_done", DONE, 1);
        tick();
        check("wrap_rd_cnt", rd_addr.size(), 32);
        check("wrap_wr_cnt", wr_addr.size(), 0);
        check("wrap_snap_cnt", rf_rd_cnt, 0);
        if (rd_addr.size() == 32) begin
            check("wrap_first", rd_addr[0], 32'hFFFF_FFF0);
            check("wrap_fifth", rd_addr[4], 32'h0000_0000);
            check("wrap_last", rd_addr[31], 32'h0000_006C);
        end
        check("wrap_rfin_w4", RF_IN_DATA[4*32 +: 32], 32'hA5A50004);
        check("wrap_rfwr_cnt", rf_wr_cnt, 1);
        tick();
        tick();
        check("wrap_idle", BUSY, 0);
        check("wrap_done_cnt", done_cnt, 1);

        check("excl_viol", excl_viol, 0);
        check("stall_viol", stall_viol, 0);
        check("idle_viol", idle_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1);
    end

endmodule
